// File: rtl/pmos_gate_seq_pkg.sv
// Shared types and constants for the PMOS leg gate sequencer.
// Gate polarity is active-low, so GATE_ALL_OFF means every leg is open.
package pmos_gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] GATE_ALL_OFF = 2'b11;
  localparam int         CNT_W        = 8;

  // Counters load N-1 so a phase of N cycles ends on the cycle the count reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pmos_gate_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; 2 cycle latency.
// Both flops clear to 0 under synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pmos_gate_seq.sv
// Sequences PMOS leg gates break-before-make, waits a settle time, then reports whether drain feedback matches.
// One request in flight; req_ready only in IDLE, result held on resp_valid until resp_ready.
module pmos_gate_seq
  import pmos_gate_seq_pkg::*;
#(
  parameter int DEAD_CYC   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  output logic [1:0] gate_n,
  input  logic       out_fb,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_ok,
  output logic [1:0] cur_sel
);

  localparam logic [CNT_W-1:0] DEAD_LD   = cnt_load(DEAD_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = cnt_load(SETTLE_CYC);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       tgt_sel;
  logic [1:0]       sel_apply;
  logic             sync_fb;
  logic             xfer;
  logic             need_break;
  logic             cnt_done;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (out_fb),
    .q   (sync_fb)
  );

  assign xfer       = req_valid && req_ready;
  assign need_break = (req_sel != cur_sel) && (cur_sel != 2'b00);
  assign cnt_done   = (cnt == '0);
  // Directly from IDLE the request itself is applied; after BREAK the latched target is.
  assign sel_apply  = (state == IDLE) ? req_sel : tgt_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer) state_nxt = need_break ? BREAK : SETTLE;
      BREAK:   if (cnt_done) state_nxt = SETTLE;
      SETTLE:  if (cnt_done) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tgt_sel <= 2'b00;
      cur_sel <= 2'b00;
      gate_n  <= GATE_ALL_OFF;
      resp_ok <= 1'b0;
    end else begin
      if (xfer) begin
        tgt_sel <= req_sel;
      end

      if (state != state_nxt && state_nxt == BREAK) begin
        cnt     <= DEAD_LD;
        gate_n  <= GATE_ALL_OFF;
        cur_sel <= 2'b00;
      end else if (state != state_nxt && state_nxt == SETTLE) begin
        cnt     <= SETTLE_LD;
        gate_n  <= ~sel_apply;
        cur_sel <= sel_apply;
      end else if (!cnt_done) begin
        cnt <= cnt - 1'b1;
      end

      if (state == SETTLE && cnt_done) begin
        resp_ok <= (sync_fb == |tgt_sel);
      end
    end
  end

endmodule

// File: tb/tb_pmos_gate_seq.sv
// Scoreboarded bench: directed sequences on a default-timing instance, random held-valid traffic on a 1/1-cycle instance.
// Every cycle both gate buses are also checked for break-before-make.
module tb_pmos_gate_seq;

  localparam int DC0 = 4, SC0 = 8, DC1 = 1, SC1 = 1;

  typedef struct {
    int         inst;
    logic [1:0] sel;
    logic       ok;
    int         due;
  } sb_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      qv, qr, rv, rr, rok, fb_in;
  logic [1:0][1:0] qs, gn, cs;

  sb_t        sbq[$];
  int         n_vec = 0, n_err = 0, cyc = 0;
  int         nxfer[2], nresp[2], rise[2];
  logic [1:0] mcur[2], gprev[2];
  logic       gvalid[2], rvq[2];

  always #5 clk = ~clk;

  pmos_gate_seq #(.DEAD_CYC(DC0), .SETTLE_CYC(SC0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(qv[0]), .req_ready(qr[0]), .req_sel(qs[0]),
    .gate_n(gn[0]), .out_fb(fb_in[0]), .resp_valid(rv[0]), .resp_ready(rr[0]),
    .resp_ok(rok[0]), .cur_sel(cs[0])
  );

  pmos_gate_seq #(.DEAD_CYC(DC1), .SETTLE_CYC(SC1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(qv[1]), .req_ready(qr[1]), .req_sel(qs[1]),
    .gate_n(gn[1]), .out_fb(fb_in[1]), .resp_valid(rv[1]), .resp_ready(rr[1]),
    .resp_ok(rok[1]), .cur_sel(cs[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bbm_viol(input logic [1:0] p, input logic [1:0] c);
    return (|(p & ~c)) && (|(~p & c));
  endfunction

  function automatic int find_q(input int k);
    foreach (sbq[i]) if (sbq[i].inst == k) return i;
    return -1;
  endfunction

  // Scoreboard monitor: push on accepted request, compare on response.
  always @(negedge clk) begin
    int  idx;
    int  d;
    int  s;
    logic brk;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? DC0 : DC1;
      s = (k == 0) ? SC0 : SC1;
      if (rst) begin
        for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].inst == k) sbq.delete(i);
        mcur[k]   = 2'b00;
        gvalid[k] = 1'b0;
        rvq[k]    = 1'b0;
      end else begin
        if (gvalid[k]) chk($sformatf("bbm%0d", k), bbm_viol(gprev[k], gn[k]), 1'b0);
        gprev[k]  = gn[k];
        gvalid[k] = 1'b1;
        if (rv[k] && !rvq[k]) rise[k] = cyc;
        if (rv[k]) begin
          idx = find_q(k);
          if (idx < 0) begin
            chk($sformatf("spurious_resp%0d", k), 1'b1, 1'b0);
          end else begin
            chk($sformatf("resp_ok%0d", k), rok[k], sbq[idx].ok);
            if (rr[k]) begin
              chk($sformatf("resp_lat%0d", k), rise[k], sbq[idx].due);
              chk($sformatf("resp_sel%0d", k), cs[k], sbq[idx].sel);
              sbq.delete(idx);
              nresp[k]++;
            end
          end
        end
        if (qv[k] && qr[k]) begin
          brk = (qs[k] != mcur[k]) && (mcur[k] != 2'b00);
          sbq.push_back('{k, qs[k], (fb_in[k] == |qs[k]), cyc + 1 + (brk ? d : 0) + s});
          mcur[k] = qs[k];
          nxfer[k]++;
        end
        rvq[k] = rv[k];
      end
    end
  end

  task automatic send(input logic [1:0] sel, input logic fb);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    fb_in[0] = fb;
    qs[0]    = sel;
    qv[0]    = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (qr[0] === 1'b1) got = 1'b1;
    end
    if (!got) chk("xfer_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    qv[0] = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (qr[0] === 1'b1 && find_q(0) < 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic seen;
    for (int k = 0; k < 2; k++) begin
      nxfer[k] = 0; nresp[k] = 0; rise[k] = 0;
      mcur[k] = 2'b00; gprev[k] = 2'b11; gvalid[k] = 1'b0; rvq[k] = 1'b0;
    end
    rst = 1'b1; qv = 2'b00; rr = 2'b11; fb_in = 2'b10; qs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gate_n", gn[0], 2'b11);
    chk("rst_cur_sel", cs[0], 2'b00);
    chk("rst_resp_valid", rv[0], 1'b0);
    chk("rst_resp_ok", rok[0], 1'b0);
    chk("rst_req_ready", qr[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // From all-off: no break, legs enable on the cycle after transfer.
    send(2'b01, 1'b1);
    @(negedge clk);
    chk("direct_gate_n", gn[0], 2'b10);
    chk("direct_cur_sel", cs[0], 2'b01);
    wait_idle();

    // Leg swap: all-off for exactly the dead time, then new legs.
    send(2'b10, 1'b1);
    for (int i = 0; i < DC0; i++) begin
      @(negedge clk);
      chk($sformatf("break_gate_n_%0d", i), gn[0], 2'b11);
      chk($sformatf("break_cur_sel_%0d", i), cs[0], 2'b00);
    end
    @(negedge clk);
    chk("post_break_gate_n", gn[0], 2'b01);
    chk("post_break_cur_sel", cs[0], 2'b10);
    wait_idle();

    // Feedback mismatch, response held under backpressure.
    rr[0] = 1'b0;
    send(2'b11, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rv[0] === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("resp_timeout", 1'b0, 1'b1);
    chk("hold_ok_first", rok[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold_valid_%0d", i), rv[0], 1'b1);
    end
    @(posedge clk); #1;
    rr[0] = 1'b1;
    @(negedge clk);
    chk("handshake_valid", rv[0], 1'b1);
    @(negedge clk);
    chk("cleared_valid", rv[0], 1'b0);
    wait_idle();

    // Same selection again: no break.
    send(2'b11, 1'b1);
    @(negedge clk);
    chk("same_sel_gate_n", gn[0], 2'b00);
    wait_idle();

    // Reset during the second settle cycle aborts without a response.
    send(2'b01, 1'b1);
    repeat (DC0 + 1) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_gate_n", gn[0], 2'b11);
    chk("abort_cur_sel", cs[0], 2'b00);
    chk("abort_resp_valid", rv[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", qr[0], 1'b1);
    repeat (SC0 + 4) @(negedge clk);
    chk("abort_no_resp", rv[0], 1'b0);

    send(2'b10, 1'b1);
    @(negedge clk);
    chk("after_rst_gate_n", gn[0], 2'b01);
    wait_idle();

    // Minimum timing, valid held high, random selects and backpressure.
    @(posedge clk); #1;
    qv[1] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      qs[1] = 2'($urandom);
      rr[1] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    qv[1] = 1'b0;
    rr[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_pending", sbq.size(), 0);
    chk("resp_count0", nresp[0], nxfer[0] - 1);
    chk("resp_count1", nresp[1], nxfer[1]);
    chk("rand_traffic", (nxfer[1] > 50), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pmos_gate_seq.md
PMOS_GATE_SEQ -- requirements
Module: pmos_gate_seq

Interface
REQ-001 Parameter DEAD_CYC, default 4: break-before-make dead time in clk cycles, legal range 1..255.
REQ-002 Parameter SETTLE_CYC, default 8: settle time before feedback is sampled, legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port req_valid, input, 1: a new leg-select request is present.
REQ-006 Port req_ready, output, 1: the block accepts a request this cycle.
REQ-007 Port req_sel, input, 2: legs to enable; bit i enables PMOS leg i.
REQ-008 Port gate_n, output, 2: active-low PMOS gate drive; bit i drives leg i gate.
REQ-009 Port out_fb, input, 1: asynchronous feedback from the shared drain node.
REQ-010 Port resp_valid, output, 1: a check result is present.
REQ-011 Port resp_ready, input, 1: the consumer accepts the result.
REQ-012 Port resp_ok, output, 1: synchronized feedback matched the expected value.
REQ-013 Port cur_sel, output, 2: the leg selection currently applied to gate_n.

Function
REQ-014 The FSM SHALL have four states: IDLE, BREAK, SETTLE and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid and req_ready are both 1.
REQ-016 On a transfer, the block SHALL latch req_sel into tgt_sel.
REQ-017 On a transfer where req_sel differs from cur_sel and cur_sel is nonzero, the FSM SHALL go to BREAK, with gate_n=2'b11 from the next cycle.
REQ-018 On a transfer where cur_sel is 00 or req_sel equals cur_sel, the FSM SHALL go directly to SETTLE (no break).
REQ-019 BREAK SHALL last exactly DEAD_CYC cycles with gate_n=2'b11 and cur_sel=00.
REQ-020 On leaving BREAK, or on entering SETTLE directly, the block SHALL set gate_n=~tgt_sel and cur_sel=tgt_sel.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles.
REQ-022 On the last SETTLE cycle, the block SHALL sample the synchronized out_fb, set resp_ok = (sync_fb == |tgt_sel), and enter RESP.
REQ-023 In RESP, resp_valid=1 and resp_ok SHALL hold stable until resp_ready=1; that handshake cycle SHALL return the FSM to IDLE.
REQ-024 The gate_n bits SHALL never go from 1 to 0 in the same cycle that any other bit goes from 0 to 1 (break-before-make).
REQ-025 out_fb SHALL pass through a 2-flop synchronizer; total feedback latency is 2 cycles and is included within SETTLE.
REQ-026 The dead-time and settle counters SHALL be 8 bits, load N-1 on state entry, and count down to 0 with no wrap.
REQ-027 req_valid held while the FSM is not in IDLE SHALL be ignored with no side effect.
REQ-028 With resp_ready tied to 1, IDLE SHALL be re-entered one cycle after resp_valid rises, so back-to-back requests are accepted every DEAD_CYC+SETTLE_CYC+2 cycles.

Reset
REQ-029 While rst=1, at each rising clk edge: state<=IDLE, gate_n<=2'b11, cur_sel<=00, resp_valid<=0, resp_ok<=0, counters<=0, synchronizer flops<=0.
REQ-030 A reset asserted mid-operation (in BREAK, SETTLE or RESP) SHALL abort the operation with no response emitted; req_ready=1 on the first cycle after rst deasserts.

Structure
REQ-031 Package pmos_gate_seq_pkg SHALL hold the state enum, the constant GATE_ALL_OFF=2'b11 and the counter width constant CNT_W=8.
REQ-032 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, clk/rst, reset value 0), instantiated once.

Verification
REQ-033 Bench: reset, then request req_sel=01 with out_fb=1 -> no break; gate_n=10 one cycle after the transfer; resp_valid after 8 cycles; resp_ok=1.
REQ-034 Bench: from cur_sel=01, request req_sel=10 -> gate_n=11 for exactly 4 cycles, then 01; 8 cycles later resp_valid=1.
REQ-035 Bench: request req_sel=11 with out_fb=0 -> resp_ok=0; resp_valid held 5 cycles while resp_ready=0, then cleared one cycle after resp_ready=1.
REQ-036 Bench: assert rst during the 2nd SETTLE cycle -> next cycle gate_n=11, cur_sel=00, resp_valid=0; req_ready=1 after rst deasserts.
REQ-037 Bench: DEAD_CYC=1, SETTLE_CYC=1, random req_sel with req_valid held high -> no resp lost, and an assertion checks REQ-024 on every cycle.
